cc_ben_unit: RTL and testbench

//  Parametrised condition-code and branch-enable unit for the LC-3 datapath.
//  - Derives N/Z/P from a WIDTH-bit bus value and holds it in the CC register.
//  - Evaluates BEN against IR[11:9].
//  - Keeps a DEPTH-entry LIFO of saved CCs for trap/interrupt entry and RTI.

---
 rtl/lc3_cc_pkg.sv | 25 ++
 rtl/cc_stack.sv | 78 +++++++
 rtl/cc_ben_unit.sv | 76 +++++++
 tb/tb_cc_ben_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_cc_pkg.sv
// Shared condition-code types and the N/Z/P classifier for the LC-3 CC/BEN unit.
package lc3_cc_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
    } cc_t;

    localparam cc_t CC_RESET = '{n: 1'b0, z: 1'b1, p: 1'b0};

    // Width-agnostic: caller supplies the sign bit and the zero test of the bus value.
    function automatic cc_t nzp_of(input logic sign, input logic zero);
        cc_t c;
        c = '0;
        if (zero)
            c.z = 1'b1;
        else if (sign)
            c.n = 1'b1;
        else
            c.p = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/cc_stack.sv
// Register-array LIFO of saved condition codes with push/pop/exchange and sticky
// overflow/underflow detection.
module cc_stack
    import lc3_cc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic clr_err,
    input  cc_t  push_data,
    output cc_t  top_c,
    output logic pop_ok_c,
    output logic empty_c,
    output logic full_c,
    output logic ovf_err,
    output logic unf_err
);

    cc_t            mem [DEPTH];
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  wr_idx;
    logic           exch;
    logic           do_push;
    logic           do_pop;
    logic           ovf_set;
    logic           unf_set;

    assign empty_c  = (cnt == '0);
    assign full_c   = (cnt == CW'(DEPTH));
    assign top_idx  = IW'(cnt - CW'(1));
    assign wr_idx   = IW'(cnt);
    assign top_c    = mem[top_idx];
    assign pop_ok_c = pop & ~empty_c;

    // Push+pop on an empty stack degrades to a plain push (and flags underflow).
    assign exch    = push & pop_ok_c;
    assign do_push = push & ~pop_ok_c & ~full_c;
    assign do_pop  = pop_ok_c & ~push;
    assign ovf_set = push & ~pop_ok_c & full_c;
    assign unf_set = pop & empty_c;

    // Entries need no reset; only the count is cleared.
    always_ff @(posedge clk) begin
        if (exch)
            mem[top_idx] <= push_data;
        else if (do_push)
            mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (do_push)
                cnt <= cnt + CW'(1);
            else if (do_pop)
                cnt <= cnt - CW'(1);
            // A new error in the same cycle as clr_err wins.
            if (ovf_set)
                ovf_err <= 1'b1;
            else if (clr_err)
                ovf_err <= 1'b0;
            if (unf_set)
                unf_err <= 1'b1;
            else if (clr_err)
                unf_err <= 1'b0;
        end
    end

endmodule

// File: rtl/cc_ben_unit.sv
// LC-3 condition-code register, branch-enable register and saved-CC stack.
// Optional CC_FORWARD_EN: LD_BEN evaluates against the CC being loaded in the same cycle.
module cc_ben_unit
    import lc3_cc_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [2:0]       ir_cond,
    input  logic             SAVE_CC,
    input  logic             RESTORE_CC,
    input  logic             clr_err,
    output logic             ben,
    output logic [2:0]       cc_out,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             ovf_err,
    output logic             unf_err
);

    cc_t  cc;
    cc_t  cc_next;
    cc_t  cc_sel;
    cc_t  cc_load;
    cc_t  top;
    logic restore_ok;

    cc_stack #(.DEPTH(DEPTH)) u_stack (
        .clk       (Clk),
        .reset     (Reset),
        .push      (SAVE_CC),
        .pop       (RESTORE_CC),
        .clr_err   (clr_err),
        .push_data (cc),
        .top_c     (top),
        .pop_ok_c  (restore_ok),
        .empty_c   (stack_empty),
        .full_c    (stack_full),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    assign cc_load = nzp_of(data[WIDTH-1], data == '0);
    assign cc_out  = cc;

    // A valid restore takes priority over LD_CC.
    always_comb begin
        cc_next = cc;
        cc_sel  = cc;
        if (restore_ok)
            cc_next = top;
        else if (LD_CC)
            cc_next = cc_load;
`ifdef CC_FORWARD_EN
        if (LD_CC)
            cc_sel = cc_next;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cc  <= CC_RESET;
            ben <= 1'b0;
        end else begin
            cc <= cc_next;
            if (LD_BEN)
                ben <= |(ir_cond & cc_sel);
        end
    end

endmodule

// File: tb/tb_cc_ben_unit.sv
// Self-checking bench for cc_ben_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_cc_ben_unit;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] dat = '0;
    logic             ld_cc = 1'b0;
    logic             ld_ben = 1'b0;
    logic [2:0]       cond = '0;
    logic             sav = 1'b0;
    logic             rsto = 1'b0;
    logic             clr = 1'b0;
    logic             ben;
    logic [2:0]       cc_out;
    logic             stack_empty;
    logic             stack_full;
    logic             ovf_err;
    logic             unf_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [2:0] m_cc  = 3'b010;
    logic       m_ben = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [2:0] m_q[$];

    cc_ben_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk         (clk),
        .Reset       (rst),
        .data        (dat),
        .LD_CC       (ld_cc),
        .LD_BEN      (ld_ben),
        .ir_cond     (cond),
        .SAVE_CC     (sav),
        .RESTORE_CC  (rsto),
        .clr_err     (clr),
        .ben         (ben),
        .cc_out      (cc_out),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] act_v();
        return {cc_out, ben, stack_empty, stack_full, ovf_err, unf_err};
    endfunction

    function automatic logic [7:0] exp_v();
        return {m_cc, m_ben, m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf};
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic r, input logic lc, input logic lb, input logic [2:0] ic,
                         input logic sv, input logic rs, input logic cl, input logic [WIDTH-1:0] d);
        logic [2:0] nz, sel, t, nxt;
        logic       rv, ovf_new, unf_new;
        rst = r; ld_cc = lc; ld_ben = lb; cond = ic; sav = sv; rsto = rs; clr = cl; dat = d;
        if (r) begin
            m_cc = 3'b010; m_ben = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_q.delete();
        end else begin
            nz = (d == 0) ? 3'b010 : (d[WIDTH-1] ? 3'b100 : 3'b001);
            rv = rs && (m_q.size() > 0);
            sel = m_cc;
`ifdef CC_FORWARD_EN
            if (lc) sel = rv ? m_q[$] : nz;
`endif
            if (lb) m_ben = |(ic & sel);
            ovf_new = sv && !rv && (m_q.size() == DEPTH);
            unf_new = rs && (m_q.size() == 0);
            if (sv && rv) begin
                t = m_q.pop_back(); m_q.push_back(m_cc); nxt = t;
            end else if (rv) begin
                nxt = m_q.pop_back();
            end else begin
                if (sv && m_q.size() < DEPTH) m_q.push_back(m_cc);
                nxt = lc ? nz : m_cc;
            end
            m_cc = nxt;
            m_ovf = ovf_new ? 1'b1 : (cl ? 1'b0 : m_ovf);
            m_unf = unf_new ? 1'b1 : (cl ? 1'b0 : m_unf);
        end
        @(posedge clk);
        #1;
        rst = 0; ld_cc = 0; ld_ben = 0; sav = 0; rsto = 0; clr = 0;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 3'b000, 0, 0, 0, '0);
        n_cmp++;
        if (act_v() !== 8'b010_0_1_0_0_0) begin
            n_fail++; $display("FAIL reset act=%b exp=%b", act_v(), 8'b010_0_1_0_0_0);
        end
    endtask

    task automatic test_classify();
        logic [WIDTH-1:0] vals [3] = '{16'h8000, 16'h0000, 16'h0001};
        logic [2:0]       exps [3] = '{3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 3'b000, 0, 0, 0, vals[i]);
            n_cmp++;
            if (cc_out !== exps[i]) begin
                n_fail++; $display("FAIL classify data=%h act=%b exp=%b", vals[i], cc_out, exps[i]);
            end
        end
    endtask

    task automatic test_ben();
        cycle(0, 1, 0, 3'b000, 0, 0, 0, 16'h0001);
        cycle(0, 0, 1, 3'b001, 0, 0, 0, '0);
        n_cmp++;
        if (ben !== 1'b1) begin n_fail++; $display("FAIL ben_match act=%b exp=1", ben); end
        cycle(0, 0, 1, 3'b110, 0, 0, 0, '0);
        n_cmp++;
        if (ben !== 1'b0) begin n_fail++; $display("FAIL ben_nomatch act=%b exp=0", ben); end
        cycle(0, 0, 0, 3'b111, 0, 0, 0, '0);
        n_cmp++;
        if (ben !== 1'b0) begin n_fail++; $display("FAIL ben_hold act=%b exp=0", ben); end
    endtask

    task automatic test_forward();
        logic fwd_exp;
`ifdef CC_FORWARD_EN
        fwd_exp = 1'b1;
`else
        fwd_exp = 1'b0;
`endif
        cycle(0, 1, 0, 3'b000, 0, 0, 0, 16'h0001);
        cycle(0, 1, 1, 3'b010, 0, 0, 0, 16'h0000);
        n_cmp++;
        if (ben !== fwd_exp || cc_out !== 3'b010) begin
            n_fail++; $display("FAIL forward act ben=%b cc=%b exp ben=%b cc=010", ben, cc_out, fwd_exp);
        end
    endtask

    task automatic test_fill_drain();
        logic [WIDTH-1:0] vals [4] = '{16'h8000, 16'h0000, 16'h0001, 16'hC000};
        logic [2:0]       pops [4] = '{3'b100, 3'b001, 3'b010, 3'b100};
        cycle(1, 0, 0, 3'b000, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 3'b000, 0, 0, 0, vals[i]);
            cycle(0, 0, 0, 3'b000, 1, 0, 0, '0);
        end
        n_cmp++;
        if (stack_full !== 1'b1 || ovf_err !== 1'b0) begin
            n_fail++; $display("FAIL fill_full act full=%b ovf=%b exp full=1 ovf=0", stack_full, ovf_err);
        end
        cycle(0, 0, 0, 3'b000, 1, 0, 0, '0);
        n_cmp++;
        if (stack_full !== 1'b1 || ovf_err !== 1'b1) begin
            n_fail++; $display("FAIL overflow act full=%b ovf=%b exp full=1 ovf=1", stack_full, ovf_err);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 3'b000, 0, 1, 0, '0);
            n_cmp++;
            if (cc_out !== pops[i] || act_v() !== exp_v()) begin
                n_fail++; $display("FAIL drain[%0d] act cc=%b vec=%b exp cc=%b vec=%b", i, cc_out, act_v(), pops[i], exp_v());
            end
        end
        cycle(0, 0, 0, 3'b000, 0, 1, 0, '0);
        n_cmp++;
        if (cc_out !== 3'b100 || unf_err !== 1'b1 || stack_empty !== 1'b1) begin
            n_fail++; $display("FAIL underflow act cc=%b unf=%b empty=%b exp cc=100 unf=1 empty=1", cc_out, unf_err, stack_empty);
        end
    endtask

    task automatic test_errors();
        cycle(0, 0, 0, 3'b000, 0, 1, 1, '0);
        n_cmp++;
        if (unf_err !== 1'b1) begin n_fail++; $display("FAIL clr_vs_set act unf=%b exp=1", unf_err); end
        cycle(0, 0, 0, 3'b000, 0, 0, 1, '0);
        n_cmp++;
        if (unf_err !== 1'b0 || ovf_err !== 1'b0) begin
            n_fail++; $display("FAIL clr_err act ovf=%b unf=%b exp 0 0", ovf_err, unf_err);
        end
    endtask

    task automatic test_exchange();
        cycle(1, 0, 0, 3'b000, 0, 0, 0, '0);
        cycle(0, 1, 0, 3'b000, 0, 0, 0, 16'h0001);
        cycle(0, 0, 0, 3'b000, 1, 0, 0, '0);
        cycle(0, 1, 0, 3'b000, 0, 0, 0, 16'h8000);
        cycle(0, 0, 0, 3'b000, 1, 1, 0, '0);
        n_cmp++;
        if (cc_out !== 3'b001 || stack_empty !== 1'b0 || act_v() !== exp_v()) begin
            n_fail++; $display("FAIL exchange act cc=%b empty=%b exp cc=001 empty=0", cc_out, stack_empty);
        end
        cycle(0, 0, 0, 3'b000, 0, 1, 0, '0);
        n_cmp++;
        if (cc_out !== 3'b100 || stack_empty !== 1'b1) begin
            n_fail++; $display("FAIL exchange_top act cc=%b empty=%b exp cc=100 empty=1", cc_out, stack_empty);
        end
        cycle(0, 0, 0, 3'b000, 1, 1, 0, '0);
        n_cmp++;
        if (act_v() !== exp_v() || unf_err !== 1'b1 || stack_empty !== 1'b0) begin
            n_fail++; $display("FAIL exchange_empty act=%b exp=%b", act_v(), exp_v());
        end
    endtask

    task automatic test_restore_priority();
        cycle(1, 0, 0, 3'b000, 0, 0, 0, '0);
        cycle(0, 1, 0, 3'b000, 0, 0, 0, 16'h0001);
        cycle(0, 0, 0, 3'b000, 1, 0, 0, '0);
        cycle(0, 1, 0, 3'b000, 0, 0, 0, 16'h0000);
        cycle(0, 1, 0, 3'b000, 0, 1, 0, 16'hFFFF);
        n_cmp++;
        if (cc_out !== 3'b001) begin n_fail++; $display("FAIL restore_prio act cc=%b exp=001", cc_out); end
        cycle(0, 1, 0, 3'b000, 0, 1, 0, 16'hFFFF);
        n_cmp++;
        if (cc_out !== 3'b100 || unf_err !== 1'b1) begin
            n_fail++; $display("FAIL restore_empty_ldcc act cc=%b unf=%b exp cc=100 unf=1", cc_out, unf_err);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 3'b000, 1, 0, 0, '0);
        cycle(1, 0, 0, 3'b000, 0, 0, 0, '0);
        n_cmp++;
        if (act_v() !== 8'b010_0_1_0_0_0) begin
            n_fail++; $display("FAIL reset_mid act=%b exp=%b", act_v(), 8'b010_0_1_0_0_0);
        end
        cycle(0, 0, 0, 3'b000, 0, 1, 0, '0);
        n_cmp++;
        if (unf_err !== 1'b1 || cc_out !== 3'b010) begin
            n_fail++; $display("FAIL reset_discard act unf=%b cc=%b exp unf=1 cc=010", unf_err, cc_out);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: d = '0;
                1: d = 16'h8000;
                2: d = 16'hFFFF;
                default: d = WIDTH'($urandom);
            endcase
            cycle($urandom_range(0, 40) == 0, 1'($urandom), 1'($urandom), 3'($urandom),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 10) == 0, d);
            n_cmp++;
            if (act_v() !== exp_v()) begin
                n_fail++; $display("FAIL random[%0d] act=%b exp=%b", i, act_v(), exp_v());
            end
        end
    endtask

    initial begin
        test_reset();
        test_classify();
        test_ben();
        test_forward();
        test_fill_drain();
        test_errors();
        test_exchange();
        test_restore_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
